// File: rtl/logic_seq_pkg.sv
// Shared types for the logic-processor command sequencer.
//   cmd_op_e    : command opcodes carried on cmd_op
//   seq_state_e : sequencer FSM states
//   cmd_t       : one queued command {op, data, f, r}
package logic_seq_pkg;

  localparam int unsigned SEQ_DATA_W = 8;
  localparam int unsigned SEQ_F_W    = 3;
  localparam int unsigned SEQ_R_W    = 2;

  typedef enum logic [1:0] {
    OP_LOADA = 2'b00,
    OP_LOADB = 2'b01,
    OP_EXEC  = 2'b10,
    OP_NOP   = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } seq_state_e;

  typedef struct packed {
    cmd_op_e                 op;
    logic [SEQ_DATA_W-1:0]   data;
    logic [SEQ_F_W-1:0]      f;
    logic [SEQ_R_W-1:0]      r;
  } cmd_t;

endpackage

// File: rtl/logic_op_sequencer_cmd_fifo.sv
// Synchronous command FIFO with occupancy count.
//   clk, rst       : clock, asynchronous active-high reset
//   i_push/i_wdata : write strobe and command (ignored when full)
//   i_pop          : read strobe (ignored when empty)
//   o_rdata        : head entry (valid when !o_empty)
//   o_count        : occupied entries; o_full / o_empty derived from it
module cmd_fifo
  import logic_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  cmd_t             i_wdata,
  input  logic             i_pop,
  output cmd_t             o_rdata,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cmd_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage array; no reset needed, occupancy is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/logic_op_sequencer.sv
// Command-driven sequencer for the 8-bit logic processor datapath.
//   Clk, Reset          : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready : command handshake into the FIFO
//   cmd_op/data/f/r     : command payload
//   Ld_A, Ld_B, D       : register unit parallel-load strobes and data
//   Shift_En            : register A/B shift enable (DATA_W cycles per EXEC)
//   F, R                : compute / router selects from last EXEC
//   busy, done          : activity flag, end-of-EXEC pulse
//   fifo_count          : queued commands
module logic_op_sequencer
  import logic_seq_pkg::*;
#(
  parameter int unsigned DATA_W     = SEQ_DATA_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [1:0]                       cmd_op,
  input  logic [DATA_W-1:0]                cmd_data,
  input  logic [2:0]                       cmd_f,
  input  logic [1:0]                       cmd_r,
  output logic                             Ld_A,
  output logic                             Ld_B,
  output logic                             Shift_En,
  output logic [DATA_W-1:0]                D,
  output logic [2:0]                       F,
  output logic [1:0]                       R,
  output logic                             busy,
  output logic                             done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

  localparam int unsigned CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);

  seq_state_e          r_state;
  seq_state_e          w_next;
  cmd_op_e             r_op;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_d;
  logic [2:0]          r_f;
  logic [1:0]          r_r;
  cmd_t                w_wcmd;
  cmd_t                w_head;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [FCNT_W-1:0]   w_count;

  // Ready follows the registered count only, so a full FIFO never accepts
  // in the same cycle as a pop.
  assign cmd_ready = !Reset && !w_full;
  assign w_push    = cmd_valid && cmd_ready;
  assign w_pop     = (r_state == ST_IDLE) && !w_empty;

  assign w_wcmd.op   = cmd_op_e'(cmd_op);
  assign w_wcmd.data = SEQ_DATA_W'(cmd_data);
  assign w_wcmd.f    = cmd_f;
  assign w_wcmd.r    = cmd_r;

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (FCNT_W)
  ) u_fifo (
    .clk     (Clk),
    .rst     (Reset),
    .i_push  (w_push),
    .i_wdata (w_wcmd),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (!w_empty) w_next = ST_ISSUE;
      ST_ISSUE: w_next = (r_op == OP_EXEC) ? ST_SHIFT : ST_IDLE;
      ST_SHIFT: if (r_cnt == '0) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Command register, datapath selects and shift counter. D/F/R are
  // captured at pop so they are already valid in the ISSUE cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_op  <= OP_NOP;
      r_cnt <= '0;
      r_d   <= '0;
      r_f   <= '0;
      r_r   <= '0;
    end else begin
      if (w_pop) begin
        r_op <= w_head.op;
        if (w_head.op == OP_LOADA || w_head.op == OP_LOADB)
          r_d <= DATA_W'(w_head.data);
        if (w_head.op == OP_EXEC) begin
          r_f <= w_head.f;
          r_r <= w_head.r;
        end
      end
      if (r_state == ST_ISSUE && r_op == OP_EXEC)
        r_cnt <= CNT_W'(DATA_W - 1);
      else if (r_state == ST_SHIFT && r_cnt != '0)
        r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Strobes decode from registered state, so Reset clears them at once.
  assign Ld_A       = (r_state == ST_ISSUE) && (r_op == OP_LOADA);
  assign Ld_B       = (r_state == ST_ISSUE) && (r_op == OP_LOADB);
  assign Shift_En   = (r_state == ST_SHIFT);
  assign done       = (r_state == ST_DONE);
  assign busy       = (r_state != ST_IDLE) || !w_empty;
  assign D          = r_d;
  assign F          = r_f;
  assign R          = r_r;
  assign fifo_count = w_count;

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Directed bench for logic_op_sequencer: reset, single loads, EXEC timing,
// FIFO back-pressure and ordering, mid-EXEC reset and NOP-only streams.
module tb_logic_op_sequencer;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic [2:0] cmd_f = 3'b000;
  logic [1:0] cmd_r = 2'b00;
  logic       Ld_A, Ld_B, Shift_En, busy, done;
  logic [7:0] D;
  logic [2:0] F;
  logic [1:0] R;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;

  logic_op_sequencer #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .cmd_f      (cmd_f),
    .cmd_r      (cmd_r),
    .Ld_A       (Ld_A),
    .Ld_B       (Ld_B),
    .Shift_En   (Shift_En),
    .D          (D),
    .F          (F),
    .R          (R),
    .busy       (busy),
    .done       (done),
    .fifo_count (fifo_count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] d,
                       input logic [2:0] f, input logic [1:0] r);
    cmd_valid = v;
    cmd_op    = op;
    cmd_data  = d;
    cmd_f     = f;
    cmd_r     = r;
  endtask

  logic [1:0] s_op [7];
  logic [7:0] s_d  [7];
  logic [2:0] s_f  [7];
  logic [1:0] s_r  [7];
  int         acc_cyc [7];
  int         ev_log [8];

  initial begin
    int ok, k, ev_n, shift_tot, first_stall, maxc, fall, seen;

    // ---------------- reset state ----------------
    #1 Reset = 1'b1;
    #2;
    chk("rst cmd_ready", 32'(cmd_ready), 0);
    chk("rst strobes", {29'd0, Ld_A, Ld_B, Shift_En}, 0);
    chk("rst done/busy", {30'd0, done, busy}, 0);
    chk("rst D/F/R", {19'd0, D, F, R}, 0);
    chk("rst fifo_count", 32'(fifo_count), 0);
    tick();
    tick();
    Reset = 1'b0;
    #1;
    chk("rel cmd_ready", 32'(cmd_ready), 1);

    // ---------------- 1: LOADA 0x33 ----------------
    drive(1'b1, 2'b00, 8'h33, 3'd0, 2'd0);
    tick();
    drive(1'b0, 2'b00, 8'h00, 3'd0, 2'd0);
    chk("t1 N+1 count", 32'(fifo_count), 1);
    chk("t1 N+1 Ld_A", 32'(Ld_A), 0);
    tick();
    chk("t1 N+2 Ld_A", 32'(Ld_A), 1);
    chk("t1 N+2 D", 32'(D), 32'h33);
    chk("t1 N+2 others", {29'd0, Ld_B, Shift_En, done}, 0);
    tick();
    chk("t1 N+3 Ld_A", 32'(Ld_A), 0);
    chk("t1 N+3 busy", 32'(busy), 0);
    chk("t1 N+3 D hold", 32'(D), 32'h33);

    // ---------------- 2: EXEC F=010 R=01 ----------------
    drive(1'b1, 2'b10, 8'hAA, 3'b010, 2'b01);
    tick();
    drive(1'b0, 2'b00, 8'h00, 3'd0, 2'd0);
    tick();
    chk("t2 issue Shift_En", 32'(Shift_En), 0);
    chk("t2 issue F/R", {27'd0, F, R}, {27'd0, 3'b010, 2'b01});
    ok = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (Shift_En && F == 3'b010 && R == 2'b01 && !done && !Ld_A && !Ld_B) ok++;
    end
    chk("t2 shift cycles", 32'(ok), 8);
    tick();
    chk("t2 done pulse", {30'd0, done, Shift_En}, 32'h2);
    chk("t2 busy at done", 32'(busy), 1);
    tick();
    chk("t2 after done", {30'd0, done, busy}, 0);
    chk("t2 hold D/F/R", {19'd0, D, F, R}, {19'd0, 8'h33, 3'b010, 2'b01});

    // ---------- 3 + 5: back-to-back stream behind a running EXEC ----------
    s_op[0] = 2'b10; s_d[0] = 8'h00; s_f[0] = 3'd1; s_r[0] = 2'd3;
    s_op[1] = 2'b00; s_d[1] = 8'h5A; s_f[1] = 3'd0; s_r[1] = 2'd0;
    s_op[2] = 2'b01; s_d[2] = 8'hC3; s_f[2] = 3'd0; s_r[2] = 2'd0;
    s_op[3] = 2'b10; s_d[3] = 8'h00; s_f[3] = 3'd5; s_r[3] = 2'd2;
    for (int i = 4; i < 7; i++) begin
      s_op[i] = 2'b11; s_d[i] = 8'hEE; s_f[i] = 3'd7; s_r[i] = 2'd3;
    end
    for (int i = 0; i < 7; i++) acc_cyc[i] = -1;
    for (int i = 0; i < 8; i++) ev_log[i] = 0;
    k = 0; ev_n = 0; shift_tot = 0; first_stall = -1; maxc = 0; fall = -1;
    for (int cyc = 0; cyc < 60 && fall < 0; cyc++) begin
      if (Ld_A && ev_n < 8)  begin ev_log[ev_n] = 32'h10000 | 32'(D); ev_n++; end
      if (Ld_B && ev_n < 8)  begin ev_log[ev_n] = 32'h20000 | 32'(D); ev_n++; end
      if (done && ev_n < 8)  begin ev_log[ev_n] = 32'h30000 | (32'(F) << 8) | 32'(R); ev_n++; end
      if (Shift_En) shift_tot++;
      if (32'(fifo_count) > maxc) maxc = 32'(fifo_count);
      if (k == 7 && !busy) fall = cyc;
      if (fall < 0) begin
        if (k < 7) drive(1'b1, s_op[k], s_d[k], s_f[k], s_r[k]);
        else       drive(1'b0, 2'b00, 8'h00, 3'd0, 2'd0);
        #1;
        if (cmd_valid && cmd_ready) begin
          acc_cyc[k] = cyc;
          k++;
        end else if (cmd_valid && first_stall < 0) begin
          first_stall = cyc;
        end
        @(posedge Clk);
        #1;
      end
    end
    drive(1'b0, 2'b00, 8'h00, 3'd0, 2'd0);
    chk("t3 event count", 32'(ev_n), 4);
    chk("t3 ev0 done f1 r3", 32'(ev_log[0]), 32'h30103);
    chk("t3 ev1 Ld_A 5A", 32'(ev_log[1]), 32'h1005A);
    chk("t3 ev2 Ld_B C3", 32'(ev_log[2]), 32'h200C3);
    chk("t3 ev3 done f5 r2", 32'(ev_log[3]), 32'h30502);
    chk("t3 shift total", 32'(shift_tot), 16);
    chk("t3 max count", 32'(maxc), 4);
    chk("t3 first stall cycle", 32'(first_stall), 5);
    chk("t3 c4 accept cycle", 32'(acc_cyc[4]), 4);
    chk("t5 accept after full pop c5", 32'(acc_cyc[5]), 13);
    chk("t5 accept after full pop c6", 32'(acc_cyc[6]), 15);
    chk("t3 busy fall cycle", 32'(fall), 33);

    // ---------------- 4: reset mid-EXEC ----------------
    drive(1'b1, 2'b10, 8'h00, 3'd3, 2'd0);
    tick();
    drive(1'b1, 2'b00, 8'h11, 3'd0, 2'd0);
    tick();
    drive(1'b0, 2'b00, 8'h00, 3'd0, 2'd0);
    tick();
    tick();
    tick();
    chk("t4 third shift", 32'(Shift_En), 1);
    chk("t4 queued count", 32'(fifo_count), 1);
    #1 Reset = 1'b1;
    #1;
    chk("t4 async Shift_En", 32'(Shift_En), 0);
    chk("t4 async count", 32'(fifo_count), 0);
    chk("t4 ready in reset", 32'(cmd_ready), 0);
    chk("t4 busy/done", {30'd0, busy, done}, 0);
    chk("t4 D/F/R cleared", {19'd0, D, F, R}, 0);
    tick();
    Reset = 1'b0;
    #1;
    chk("t4 ready after release", 32'(cmd_ready), 1);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (Ld_A || Ld_B || Shift_En || done || busy) seen++;
    end
    chk("t4 no activity after reset", 32'(seen), 0);

    // ---------------- 6: NOP-only stream ----------------
    drive(1'b1, 2'b01, 8'h77, 3'd0, 2'd0);
    tick();
    drive(1'b0, 2'b00, 8'h00, 3'd0, 2'd0);
    tick();
    tick();
    chk("t6 pre D", 32'(D), 32'h77);
    seen = 0; fall = -1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (Ld_A || Ld_B || Shift_En || done) seen++;
      if (cyc >= 1 && !busy && fall < 0) fall = cyc;
      if (cyc < 3) drive(1'b1, 2'b11, 8'hFF, 3'd7, 2'd3);
      else         drive(1'b0, 2'b00, 8'h00, 3'd0, 2'd0);
      tick();
    end
    chk("t6 no strobes", 32'(seen), 0);
    chk("t6 busy fall cycle", 32'(fall), 7);
    chk("t6 hold D/F/R", {19'd0, D, F, R}, {19'd0, 8'h77, 3'd0, 2'd0});
    chk("t6 drained", 32'(fifo_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
